// File: rtl/hb_pkg.sv
// Shared types for the heart-bit monitor: FSM states, fault codes and the
// width helper used to size the interval counter.
package hb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACQUIRE = 3'd1,
        CHECK   = 3'd2,
        ALIVE   = 3'd3,
        FAULT   = 3'd4
    } hb_state_t;

    typedef enum logic [1:0] {
        FC_NONE  = 2'b00,
        FC_EARLY = 2'b01,
        FC_LATE  = 2'b10
    } hb_fault_t;

    // Room for EXP+TOL (saturation point) and EXP+TOL+1 (a late edge's measurement).
    function automatic int unsigned hb_width(input int unsigned exp_counts,
                                             input int unsigned tol);
        return $clog2(exp_counts + tol + 2);
    endfunction

endpackage

// File: rtl/hb_sync_edge.sv
// Multi-flop synchronizer for the asynchronous heart bit, followed by an
// any-polarity edge detector producing a one-cycle pulse.
module hb_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic hb_edge
);

    logic [STAGES-1:0] sync;
    logic              last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            last <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            last <= sync[STAGES-1];
        end
    end

    assign hb_edge = sync[STAGES-1] ^ last;

endmodule

// File: rtl/heart_bit_monitor.sv
// Heart-bit monitor: measures the interval between heart-bit transitions,
// declares the source alive after a run of in-window intervals, latches faults.
module heart_bit_monitor
    import hb_pkg::*;
#(
    parameter int unsigned EXP_HALF_COUNTS = 50_000_000,
    parameter int unsigned TOLERANCE       = 500_000,
    parameter int unsigned LOCK_EDGES      = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    localparam int unsigned W              = hb_width(EXP_HALF_COUNTS, TOLERANCE)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         hb_in,
    input  logic         clear_fault,
    output logic         alive,
    output logic         fault,
    output logic [1:0]   fault_code,
    output logic [W-1:0] half_period,
    output logic         period_valid
);

    localparam logic [W-1:0]  MAX_CNT   = W'(EXP_HALF_COUNTS + TOLERANCE);
    localparam logic [W-1:0]  MIN_OK    = W'(EXP_HALF_COUNTS - TOLERANCE);
    localparam int unsigned   GW        = $clog2(LOCK_EDGES + 1);
    localparam logic [GW-1:0] LAST_GOOD = GW'(LOCK_EDGES - 1);

    logic          hb_edge;
    hb_state_t     state, state_n;
    hb_fault_t     code_n;
    logic [W-1:0]  cnt, cnt_n, measured, hp_n;
    logic [GW-1:0] good, good_n;
    logic          pv_n;

    hb_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .din     (hb_in),
        .hb_edge (hb_edge)
    );

    // counter holds cycles-since-edge minus one, so an edge N cycles later measures N
    assign measured = cnt + W'(1);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        good_n  = good;
        code_n  = hb_fault_t'(fault_code);
        hp_n    = half_period;
        pv_n    = 1'b0;

        if (state == ACQUIRE || state == CHECK || state == ALIVE) begin
            cnt_n = (cnt == MAX_CNT) ? cnt : cnt + W'(1);
        end

        if (clear_fault) begin
            state_n = ACQUIRE;
            cnt_n   = '0;
            good_n  = '0;
            code_n  = FC_NONE;
        end else if (state == FAULT) begin
            cnt_n = cnt;
        end else if (!enable) begin
            state_n = IDLE;
            cnt_n   = '0;
            good_n  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = ACQUIRE;
                    cnt_n   = '0;
                end
                ACQUIRE: begin
                    if (hb_edge) begin
                        state_n = CHECK;
                        cnt_n   = '0;
                        good_n  = '0;
                    end
                end
                CHECK, ALIVE: begin
                    if (hb_edge) begin
                        cnt_n = '0;
                        hp_n  = measured;
                        pv_n  = 1'b1;
                        if (measured < MIN_OK) begin
                            state_n = FAULT;
                            code_n  = FC_EARLY;
                        end else if (measured > MAX_CNT) begin
                            state_n = FAULT;
                            code_n  = FC_LATE;
                        end else if (state == CHECK) begin
                            good_n = good + GW'(1);
                            if (good == LAST_GOOD) state_n = ALIVE;
                        end
                    end else if (cnt == MAX_CNT) begin
                        state_n = FAULT;
                        code_n  = FC_LATE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            good         <= '0;
            fault_code   <= FC_NONE;
            half_period  <= '0;
            period_valid <= 1'b0;
            alive        <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            good         <= good_n;
            fault_code   <= code_n;
            half_period  <= hp_n;
            period_valid <= pv_n;
            alive        <= (state_n == ALIVE);
            fault        <= (state_n == FAULT);
        end
    end

endmodule

// File: tb/tb_heart_bit_monitor.sv
// Self-checking bench for heart_bit_monitor: randomized heart-bit intervals
// against a timestamp-based reference model, compared every cycle.
module tb_heart_bit_monitor;

    localparam int EXP  = 10;
    localparam int TOL  = 1;
    localparam int LOCK = 4;
    localparam int SYNC = 2;
    localparam int W    = $clog2(EXP + TOL + 2);

    localparam int M_IDLE = 0, M_ACQ = 1, M_CHECK = 2, M_ALIVE = 3, M_FAULT = 4;

    logic         clk = 1'b0;
    logic         rst, enable, hb_in, clear_fault;
    logic         alive, fault, period_valid;
    logic [1:0]   fault_code;
    logic [W-1:0] half_period;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];

    // reference model state
    int         m_mode, m_now, m_last_t, m_good, m_hp;
    logic [3:0] m_smp;
    logic       m_alive, m_fault, m_pv;
    logic [1:0] m_code;

    heart_bit_monitor #(
        .EXP_HALF_COUNTS (EXP),
        .TOLERANCE       (TOL),
        .LOCK_EDGES      (LOCK),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .hb_in        (hb_in),
        .clear_fault  (clear_fault),
        .alive        (alive),
        .fault        (fault),
        .fault_code   (fault_code),
        .half_period  (half_period),
        .period_valid (period_valid)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_now   = 0;
        m_last_t = 0;
        m_good  = 0;
        m_hp    = 0;
        m_smp   = 4'b0;
        m_alive = 1'b0;
        m_fault = 1'b0;
        m_pv    = 1'b0;
        m_code  = 2'b00;
    endtask

    // Transitions are judged by their timestamps: a transition sampled at
    // edge k is acted upon at edge k+SYNC.
    task automatic model_step();
        int  iv;
        bit  seen;
        if (rst) begin
            model_reset();
            return;
        end
        m_now++;
        m_smp = {m_smp[2:0], hb_in};
        seen  = (m_smp[SYNC] != m_smp[SYNC+1]);
        m_pv  = 1'b0;
        if (clear_fault) begin
            m_mode = M_ACQ;
            m_code = 2'b00;
            m_good = 0;
        end else if (m_mode == M_FAULT) begin
            // latched until cleared
        end else if (!enable) begin
            m_mode = M_IDLE;
            m_good = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_ACQ;
        end else if (m_mode == M_ACQ) begin
            if (seen) begin
                m_last_t = m_now;
                m_mode   = M_CHECK;
                m_good   = 0;
            end
        end else if (seen) begin
            iv       = m_now - m_last_t;
            m_last_t = m_now;
            m_hp     = iv;
            m_pv     = 1'b1;
            exp_q.push_back(W'(iv));
            if (iv < EXP - TOL) begin
                m_mode = M_FAULT;
                m_code = 2'b01;
            end else if (iv > EXP + TOL) begin
                m_mode = M_FAULT;
                m_code = 2'b10;
            end else if (m_mode == M_CHECK) begin
                m_good++;
                if (m_good == LOCK) m_mode = M_ALIVE;
            end
        end else if (m_now - m_last_t == EXP + TOL + 1) begin
            m_mode = M_FAULT;
            m_code = 2'b10;
        end
        m_alive = (m_mode == M_ALIVE);
        m_fault = (m_mode == M_FAULT);
    endtask

    task automatic check_outputs();
        logic [W-1:0] e;
        check_val("alive", alive, m_alive);
        check_val("fault", fault, m_fault);
        check_val("fault_code", fault_code, m_code);
        check_val("period_valid", period_valid, m_pv);
        check_val("half_period", half_period, m_hp);
        if (period_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("sb_interval", half_period, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic toggle_wait(input int n);
        hb_in = ~hb_in;
        repeat (n) tick();
    endtask

    task automatic pulse_clear();
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        enable = 1'b0;
        hb_in = 1'b0;
        clear_fault = 1'b0;
        model_reset();
        #2;
        check_outputs();
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // steady 10-cycle toggling locks after five edges
        enable = 1'b1;
        repeat (5) toggle_wait(10);
        repeat (3) toggle_wait($urandom_range(9, 11));

        // short interval while locked
        toggle_wait(8);
        repeat (2) toggle_wait(10);

        // clear_fault lands on the cycle an edge is acted upon
        hb_in = ~hb_in;
        repeat (2) tick();
        pulse_clear();
        repeat (7) tick();
        repeat (5) toggle_wait(10);

        // boundary intervals accepted, then stuck heart bit
        toggle_wait(9);
        toggle_wait(11);
        toggle_wait(20);
        pulse_clear();

        // enable dropped mid-CHECK
        repeat (3) toggle_wait(10);
        enable = 1'b0;
        repeat (4) tick();
        enable = 1'b1;
        repeat (6) toggle_wait(10);

        // randomized intervals with occasional clears and enable drops
        for (int i = 0; i < 60; i++) begin
            n = ($urandom_range(0, 9) < 7) ? $urandom_range(9, 11) : $urandom_range(6, 14);
            toggle_wait(n);
            if ($urandom_range(0, 7) == 0) pulse_clear();
            if ($urandom_range(0, 11) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                enable = 1'b1;
            end
        end

        // relock, then asynchronous reset between clock edges
        pulse_clear();
        repeat (6) toggle_wait(10);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        repeat (6) toggle_wait(10);
        repeat (3) tick();

        check_val("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
